// File: rtl/hazard_scoreboard.sv
// Load-use stall / flush bubble control with a DEPTH-entry shift-register scoreboard and
// registered forwarding selects. Optional stall/flush counters: define HAZARD_STATS_EN.
module hazard_scoreboard #(
   parameter int NUM_REGS   = 32,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   localparam int RAW       = $clog2(NUM_REGS),
   localparam int FSW       = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           id_valid,
   input  logic [RAW-1:0] id_rs1,
   input  logic [RAW-1:0] id_rs2,
   input  logic           id_rs1_used,
   input  logic           id_rs2_used,
   input  logic [RAW-1:0] id_rd,
   input  logic           id_reg_write,
   input  logic           id_mem_read,
   input  logic           flush_i,
   output logic           stall_o,
   output logic           pc_write_en,
   output logic           if_id_write_en,
   output logic           id_ex_bubble,
   output logic [FSW-1:0] fwd_sel_rs1,
   output logic [FSW-1:0] fwd_sel_rs2
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]    stall_count,
   output logic [31:0]    flush_count
`endif
);

   logic [DEPTH-1:0] r_v;
   logic [DEPTH-1:0] r_rw;
   logic [DEPTH-1:0] r_ld;
   logic [RAW-1:0]   r_rd [DEPTH];
   logic [FSW-1:0]   r_sel1;
   logic [FSW-1:0]   r_sel2;

   logic [DEPTH-1:0] w_m1;
   logic [DEPTH-1:0] w_m2;
   logic             w_ld_hit;
   logic             w_stall;
   logic             w_bubble;
   logic             w_issue;
   logic [FSW-1:0]   w_sel1;
   logic [FSW-1:0]   w_sel2;
   logic             w_f1;
   logic             w_f2;

   always_comb begin
      w_m1 = '0;
      w_m2 = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
         w_m1[j] = r_v[j] & r_rw[j] & (r_rd[j] == id_rs1) & (id_rs1 != '0) & id_rs1_used;
         w_m2[j] = r_v[j] & r_rw[j] & (r_rd[j] == id_rs2) & (id_rs2 != '0) & id_rs2_used;
      end
   end

   // A load only stalls while its data is still upstream of LOAD_STAGE's output.
   always_comb begin
      w_ld_hit = 1'b0;
      for (int unsigned j = 0; j < DEPTH - 1; j++) begin
         if (((j + 1) < LOAD_STAGE) && r_ld[j] && (w_m1[j] || w_m2[j]))
            w_ld_hit = 1'b1;
      end
   end

   assign w_stall  = ~reset & ~flush_i & id_valid & w_ld_hit;
   assign w_bubble = w_stall | flush_i;
   assign w_issue  = id_valid & ~w_bubble;

   // Youngest producer wins; WB (last entry) is excluded since the regfile writes through.
   always_comb begin
      w_sel1 = '0;
      w_sel2 = '0;
      w_f1   = 1'b0;
      w_f2   = 1'b0;
      for (int unsigned j = 0; j < DEPTH - 1; j++) begin
         if (w_m1[j] && !w_f1) begin
            w_sel1 = FSW'(j + 1);
            w_f1   = 1'b1;
         end
         if (w_m2[j] && !w_f2) begin
            w_sel2 = FSW'(j + 1);
            w_f2   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v    <= '0;
         r_rw   <= '0;
         r_ld   <= '0;
         r_sel1 <= '0;
         r_sel2 <= '0;
         for (int unsigned j = 0; j < DEPTH; j++)
            r_rd[j] <= '0;
      end else begin
         for (int unsigned j = 1; j < DEPTH; j++) begin
            r_v[j]  <= r_v[j-1];
            r_rw[j] <= r_rw[j-1];
            r_ld[j] <= r_ld[j-1];
            r_rd[j] <= r_rd[j-1];
         end
         r_v[0]  <= w_issue;
         r_rw[0] <= id_reg_write;
         r_ld[0] <= id_mem_read;
         r_rd[0] <= id_rd;
         r_sel1  <= w_issue ? w_sel1 : '0;
         r_sel2  <= w_issue ? w_sel2 : '0;
      end
   end

   assign stall_o        = w_stall;
   assign pc_write_en    = ~w_stall | flush_i;
   assign if_id_write_en = ~w_stall | flush_i;
   assign id_ex_bubble   = w_bubble;
   assign fwd_sel_rs1    = r_sel1;
   assign fwd_sel_rs2    = r_sel2;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush_i && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance (DEPTH=3, LOAD_STAGE=2)
// plus a DEPTH=5, LOAD_STAGE=3 instance sharing the same ID-stage stimulus.
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       flush_i;

   logic       stall_o, pc_write_en, if_id_write_en, id_ex_bubble;
   logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
   logic       stall5, pcwe5, ifidwe5, bubble5;
   logic [2:0] fwd5_rs1, fwd5_rs2;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc3, fc3, sc5, fc5;
`endif

   int n_cmp = 0;
   int n_err = 0;

   hazard_scoreboard #(.NUM_REGS(32), .DEPTH(3), .LOAD_STAGE(2)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush_i(flush_i),
      .stall_o(stall_o), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .id_ex_bubble(id_ex_bubble), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2)
`ifdef HAZARD_STATS_EN
      , .stall_count(sc3), .flush_count(fc3)
`endif
   );

   hazard_scoreboard #(.NUM_REGS(32), .DEPTH(5), .LOAD_STAGE(3)) u_dut5 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush_i(flush_i),
      .stall_o(stall5), .pc_write_en(pcwe5), .if_id_write_en(ifidwe5),
      .id_ex_bubble(bubble5), .fwd_sel_rs1(fwd5_rs1), .fwd_sel_rs2(fwd5_rs2)
`ifdef HAZARD_STATS_EN
      , .stall_count(sc5), .flush_count(fc5)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next falling edge and present one ID-stage instruction.
   task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic fl);
      @(negedge clk);
      id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = ld; flush_i = fl;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", stall_o); end
      n_cmp++; if (pc_write_en !== 1'b1) begin n_err++; $display("FAIL rst_pcwe: got %0b want 1", pc_write_en); end
      n_cmp++; if (if_id_write_en !== 1'b1) begin n_err++; $display("FAIL rst_ifidwe: got %0b want 1", if_id_write_en); end
      n_cmp++; if (id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %0b want 0", id_ex_bubble); end
      n_cmp++; if (fwd_sel_rs1 !== 2'd0) begin n_err++; $display("FAIL rst_fwd1: got %0d want 0", fwd_sel_rs1); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd0) begin n_err++; $display("FAIL rst_fwd2: got %0d want 0", fwd_sel_rs2); end
   endtask

   task automatic test_alu_forward();
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0);                 // add x5
      drive(1, 5, 1, 3, 1, 9, 1, 0, 0);                 // sub rs1=x5
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %0b want 0", stall_o); end
      idle(1);                                          // sub now in EX
      n_cmp++; if (fwd_sel_rs1 !== 2'd1) begin n_err++; $display("FAIL alu_fwd1: got %0d want 1", fwd_sel_rs1); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd0) begin n_err++; $display("FAIL alu_fwd2_other: got %0d want 0", fwd_sel_rs2); end
      drive(1, 0, 0, 5, 1, 10, 1, 0, 0);                // x5 producer now in WB
      idle(1);
      n_cmp++; if (fwd_sel_rs2 !== 2'd0) begin n_err++; $display("FAIL alu_wb_nofwd: got %0d want 0", fwd_sel_rs2); end
      idle(3);
   endtask

   task automatic test_load_use();
      drive(1, 1, 1, 0, 0, 6, 1, 1, 0);                 // lw x6
      drive(1, 1, 1, 6, 1, 10, 1, 0, 0);                // add rs2=x6
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", stall_o); end
      n_cmp++; if (id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %0b want 1", id_ex_bubble); end
      n_cmp++; if (pc_write_en !== 1'b0) begin n_err++; $display("FAIL lu_pcwe: got %0b want 0", pc_write_en); end
      n_cmp++; if (if_id_write_en !== 1'b0) begin n_err++; $display("FAIL lu_ifidwe: got %0b want 0", if_id_write_en); end
      drive(1, 1, 1, 6, 1, 10, 1, 0, 0);                // held in ID
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_stall_once: got %0b want 0", stall_o); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd0) begin n_err++; $display("FAIL lu_bubble_fwd: got %0d want 0", fwd_sel_rs2); end
      idle(1);
      n_cmp++; if (fwd_sel_rs2 !== 2'd2) begin n_err++; $display("FAIL lu_fwd2: got %0d want 2", fwd_sel_rs2); end
      n_cmp++; if (fwd_sel_rs1 !== 2'd0) begin n_err++; $display("FAIL lu_fwd1: got %0d want 0", fwd_sel_rs1); end
      idle(3);
   endtask

   task automatic test_x0();
      drive(1, 1, 1, 0, 0, 0, 1, 1, 0);                 // load writing x0
      drive(1, 0, 1, 0, 1, 11, 1, 0, 0);                // reads x0 twice
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %0b want 0", stall_o); end
      idle(1);
      n_cmp++; if (fwd_sel_rs1 !== 2'd0) begin n_err++; $display("FAIL x0_fwd1: got %0d want 0", fwd_sel_rs1); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd0) begin n_err++; $display("FAIL x0_fwd2: got %0d want 0", fwd_sel_rs2); end
      idle(3);
   endtask

   task automatic test_flush();
      drive(1, 1, 1, 0, 0, 7, 1, 1, 0);                 // lw x7
      drive(1, 7, 1, 0, 0, 12, 1, 0, 1);                // consumer + flush
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %0b want 0", stall_o); end
      n_cmp++; if (id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL fl_bubble: got %0b want 1", id_ex_bubble); end
      n_cmp++; if (pc_write_en !== 1'b1) begin n_err++; $display("FAIL fl_pcwe: got %0b want 1", pc_write_en); end
      n_cmp++; if (if_id_write_en !== 1'b1) begin n_err++; $display("FAIL fl_ifidwe: got %0b want 1", if_id_write_en); end
      idle(1);
      n_cmp++; if (fwd_sel_rs1 !== 2'd0) begin n_err++; $display("FAIL fl_fwd1: got %0d want 0", fwd_sel_rs1); end
      idle(3);
   endtask

   task automatic test_youngest();
      drive(1, 1, 1, 0, 0, 8, 1, 0, 0);                 // add x8
      drive(1, 2, 1, 0, 0, 8, 1, 0, 0);                 // add x8 again
      drive(1, 8, 1, 8, 1, 13, 1, 0, 0);                // rs1 == rs2 == x8
      idle(1);
      n_cmp++; if (fwd_sel_rs1 !== 2'd1) begin n_err++; $display("FAIL yg_fwd1: got %0d want 1", fwd_sel_rs1); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd1) begin n_err++; $display("FAIL yg_fwd2: got %0d want 1", fwd_sel_rs2); end
      idle(3);
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 1, 0, 0, 11, 1, 0, 0);                // add x11
      drive(1, 2, 1, 0, 0, 12, 1, 0, 0);                // unrelated
      drive(1, 11, 1, 12, 1, 14, 1, 0, 0);              // x11 in stage 1, x12 in stage 0
      idle(1);
      n_cmp++; if (fwd_sel_rs1 !== 2'd2) begin n_err++; $display("FAIL b2b_fwd1: got %0d want 2", fwd_sel_rs1); end
      n_cmp++; if (fwd_sel_rs2 !== 2'd1) begin n_err++; $display("FAIL b2b_fwd2: got %0d want 1", fwd_sel_rs2); end
      idle(3);
   endtask

   task automatic test_deep_load();
      do_reset();
      drive(1, 1, 1, 0, 0, 6, 1, 1, 0);                 // lw x6
      drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
      n_cmp++; if (stall5 !== 1'b1) begin n_err++; $display("FAIL dl_stall1: got %0b want 1", stall5); end
      drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
      n_cmp++; if (stall5 !== 1'b1) begin n_err++; $display("FAIL dl_stall2: got %0b want 1", stall5); end
      drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
      n_cmp++; if (stall5 !== 1'b0) begin n_err++; $display("FAIL dl_stall3: got %0b want 0", stall5); end
      idle(1);
      n_cmp++; if (fwd5_rs2 !== 3'd3) begin n_err++; $display("FAIL dl_fwd2: got %0d want 3", fwd5_rs2); end
      idle(5);
      drive(1, 1, 1, 0, 0, 6, 1, 1, 0);                 // lw x6 again
      drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
      n_cmp++; if (stall5 !== 1'b1) begin n_err++; $display("FAIL dl_rs_pre: got %0b want 1", stall5); end
      reset = 1'b1;                                     // reset during first stall cycle
      drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
      reset = 1'b0;
      #1;
      n_cmp++; if (stall5 !== 1'b0) begin n_err++; $display("FAIL dl_rs_stall: got %0b want 0", stall5); end
      n_cmp++; if (fwd5_rs2 !== 3'd0) begin n_err++; $display("FAIL dl_rs_fwd: got %0d want 0", fwd5_rs2); end
      idle(5);
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush_i = 0;
      test_reset();
      test_alu_forward();
      test_load_use();
      test_x0();
      test_flush();
      test_youngest();
      test_back_to_back();
      test_deep_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
